seg7_scan_driver: RTL
=====================

// Module: seg7_scan_driver
// PURPOSE
//  Time-multiplexed driver for an N-digit common-anode/cathode 7-segment display.
//  Latches a packed hex word, scans one digit per slot, decodes each nibble to segments,
//  inserts anode dead-time between slots (anti-ghosting), optional leading-zero blanking.
//  Sits between datapath result registers (e.g. 4-bit adder sum) and board display pins.
// PARAMETERS
//  N_DIGITS       4      number of digits, >=1
//  SCAN_DIV       50000  clk cycles each digit is lit per slot, >=1
//  DEAD_CYC       2      clk cycles all anodes off between slots, >=0 (0 = no dead state)
//  SEG_ACT_LOW    0      1: seg/dp pins active-low (inverted at output register)
//  AN_ACT_LOW     1      1: anode pins active-low
//  BLANK_LEADING  1      1: suppress leading zeros (digit 0 never suppressed)
// PORTS
//  clk       in   1            system clock
//  rst_n     in   1            asynchronous, active-low reset
//  value     in   4*N_DIGITS   hex digits, digit i = value[4i+3:4i], digit 0 rightmost
//  dp_in     in   N_DIGITS     decimal point per digit
//  digit_en  in   N_DIGITS     per-digit enable; 0 keeps that anode off for its slot
//  load      in   1            strobe: capture value/dp_in/digit_en into shadow regs
//  seg       out  7            segments {a,b,c,d,e,f,g}, polarity per SEG_ACT_LOW
//  dp        out  1            decimal point, polarity per SEG_ACT_LOW
//  an        out  N_DIGITS     digit anodes, one-hot when lit, polarity per AN_ACT_LOW
// BEHAVIOUR
//  Reset (async assert, sync release): shadow regs 0, idx=0, cnt=0, state=SHOW;
//   seg/dp/an at inactive level (segments off, all anodes off).
//  Shadow: on edge with load=1 capture inputs; outputs use shadow only -> value change
//   sampled at edge k appears on pins at edge k+1 (outputs registered, 1-cycle latency).
//  FSM states SHOW, DEAD:
//   SHOW: cnt counts 0..SCAN_DIV-1; at SCAN_DIV-1: cnt<=0, idx<=(idx==N_DIGITS-1)?0:idx+1,
//         next=DEAD if DEAD_CYC>0 else SHOW.
//   DEAD: all anodes inactive, seg/dp inactive; cnt counts 0..DEAD_CYC-1, then SHOW, cnt<=0.
//  Registered outputs in SHOW: an one-hot at idx if shadow_en[idx] else all off;
//   seg = hex7(nibble[idx]) unless blanked; dp = shadow_dp[idx].
//  Blanked digit i: BLANK_LEADING && i>0 && nibbles i..N_DIGITS-1 all zero -> seg off, dp kept.
//  hex7 table (active-high a..g): 0 1111110, 1 0110000, 2 1101101, 3 1111001,
//   4 0110011, 5 1011011, 6 1011111, 7 1110000, 8 1111111, 9 1110011,
//   A 1110111, b 0011111, C 1001110, d 0111101, E 1001111, F 1000111.
//  Widths: idx $clog2(N_DIGITS) (min 1), cnt $clog2(max(SCAN_DIV,DEAD_CYC)) (min 1).
//  Boundaries: N_DIGITS=1 -> idx stays 0; load every cycle legal; load in DEAD legal,
//   shown at next SHOW; digit_en=0 still consumes its slot time (uniform refresh);
//   reset mid-slot -> outputs inactive immediately, scan restarts at digit 0.
// STRUCTURE
//  seg7_pkg: hex7 segment constant table/function, scan_state_t enum {SHOW, DEAD}.
//  Sub-module hex_to_seg7 (combinational nibble -> 7 bits active-high); one instance on
//   selected nibble; polarity inversion only at output register.
// TESTING (N_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1, AN_ACT_LOW=1, SEG_ACT_LOW=0)
//  1 reset held, then release -> an=4'b1111, seg=0 during reset; first lit an=4'b1110.
//  2 load value=16'h12AF, en=4'hF, BLANK_LEADING=0 -> slots show 1000111(F), 1110111(A),
//    1101101(2), 0110000(1); each lit 4 cycles, an=1111 for 1 cycle between.
//  3 value=16'h0005, BLANK_LEADING=1 -> digit0 seg=1011011; digits1-3 seg=0, anode lit.
//  4 value=16'h0000 -> digit0 seg=1111110, digits1-3 blank; dp_in=4'b0100 -> dp=1 on digit2.
//  5 digit_en=4'b1101 -> an stays 1111 through digit1 slot; slot period still 4+1 cycles.
//  6 rst_n low mid digit2 slot -> an=1111 same cycle (async); after release scan from digit0;
//    load 16'h6B00 mid-scan -> 6 shows 1011111, b shows 0011111 (distinct).

Source files
------------

// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - shared types, segment table and sizing helper for the 7-segment scan driver
package seg7_pkg;

    // Scan sequencer states: a digit is lit in SHOW, all anodes are off in DEAD.
    typedef enum logic {
        SHOW = 1'b0,
        DEAD = 1'b1
    } scan_state_t;

    // Active-high segment pattern with every segment dark.
    localparam logic [6:0] SEG_NONE = 7'b000_0000;

    // Hex nibble to active-high segments, bit order {a,b,c,d,e,f,g}.
    function automatic logic [6:0] hex7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b1111110;
            4'h1:    s = 7'b0110000;
            4'h2:    s = 7'b1101101;
            4'h3:    s = 7'b1111001;
            4'h4:    s = 7'b0110011;
            4'h5:    s = 7'b1011011;
            4'h6:    s = 7'b1011111;
            4'h7:    s = 7'b1110000;
            4'h8:    s = 7'b1111111;
            4'h9:    s = 7'b1110011;
            4'hA:    s = 7'b1110111;
            4'hB:    s = 7'b0011111;
            4'hC:    s = 7'b1001110;
            4'hD:    s = 7'b0111101;
            4'hE:    s = 7'b1001111;
            default: s = 7'b1000111;
        endcase
        return s;
    endfunction

    // Register width able to hold 0..m-1, never narrower than one bit.
    function automatic int clog2_min1(input int m);
        return (m > 1) ? $clog2(m) : 1;
    endfunction

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-high 7-segment decoder
module hex_to_seg7
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    // Pure table lookup; polarity is handled by whoever registers the result.
    always_comb begin
        seg = hex7(nibble);
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// rtl/seg7_scan_driver.sv - time-multiplexed N-digit 7-segment driver with dead-time and zero blanking
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int N_DIGITS      = 4,
    parameter int SCAN_DIV      = 50000,
    parameter int DEAD_CYC      = 2,
    parameter int SEG_ACT_LOW   = 0,
    parameter int AN_ACT_LOW    = 1,
    parameter int BLANK_LEADING = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_in,
    input  logic [N_DIGITS-1:0]     digit_en,
    input  logic                    load,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [N_DIGITS-1:0]     an
);

    localparam int IDX_W   = clog2_min1(N_DIGITS);
    localparam int CNT_MAX = (SCAN_DIV > DEAD_CYC) ? SCAN_DIV : DEAD_CYC;
    localparam int CNT_W   = clog2_min1(CNT_MAX);

    localparam logic [CNT_W-1:0] SCAN_LAST = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    // Inactive pin levels; XOR with these applies the pin polarity at the output register.
    localparam logic [6:0]          SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                DP_OFF  = (SEG_ACT_LOW != 0);
    localparam logic [N_DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? '1 : '0;

    logic [4*N_DIGITS-1:0] shadow_val;
    logic [N_DIGITS-1:0]   shadow_dp;
    logic [N_DIGITS-1:0]   shadow_en;

    scan_state_t           state;
    logic [IDX_W-1:0]      idx;
    logic [CNT_W-1:0]      cnt;

    logic [3:0]            sel_nib;
    logic                  sel_dp;
    logic                  sel_en;
    logic                  sel_blank;
    logic [N_DIGITS-1:0]   an_hot;
    logic [N_DIGITS-1:0]   lz;
    logic                  zero_above;
    logic [6:0]            seg_raw;

    // Shadow copy of the display inputs so the pins never see a half-updated word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_val <= '0;
            shadow_dp  <= '0;
            shadow_en  <= '0;
        end else if (load) begin
            shadow_val <= value;
            shadow_dp  <= dp_in;
            shadow_en  <= digit_en;
        end
    end

    // Leading-zero mask from the top digit down, then select everything for the current digit.
    always_comb begin
        sel_nib    = 4'h0;
        sel_dp     = 1'b0;
        sel_en     = 1'b0;
        sel_blank  = 1'b0;
        an_hot     = '0;
        lz         = '0;
        zero_above = 1'b1;
        for (int i = N_DIGITS - 1; i >= 0; i--) begin
            zero_above = zero_above & (shadow_val[4*i +: 4] == 4'h0);
            lz[i]      = zero_above;
        end
        for (int i = 0; i < N_DIGITS; i++) begin
            if (idx == IDX_W'(i)) begin
                sel_nib   = shadow_val[4*i +: 4];
                sel_dp    = shadow_dp[i];
                sel_en    = shadow_en[i];
                sel_blank = (BLANK_LEADING != 0) && (i > 0) && lz[i];
                an_hot[i] = 1'b1;
            end
        end
    end

    hex_to_seg7 u_dec (
        .nibble (sel_nib),
        .seg    (seg_raw)
    );

    // Scan sequencer: lit slot of SCAN_DIV cycles per digit, then optional dead-time, pins registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SHOW;
            idx   <= '0;
            cnt   <= '0;
            seg   <= SEG_OFF;
            dp    <= DP_OFF;
            an    <= AN_OFF;
        end else begin
            case (state)
                SHOW: begin
                    seg <= (sel_blank ? SEG_NONE : seg_raw) ^ SEG_OFF;
                    dp  <= sel_dp ^ DP_OFF;
                    an  <= (sel_en ? an_hot : '0) ^ AN_OFF;
                    if (cnt == SCAN_LAST) begin
                        cnt   <= '0;
                        idx   <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
                        state <= (DEAD_CYC > 0) ? DEAD : SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEAD: begin
                    seg <= SEG_OFF;
                    dp  <= DP_OFF;
                    an  <= AN_OFF;
                    if (cnt == DEAD_LAST) begin
                        cnt   <= '0;
                        state <= SHOW;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
